// File: rtl/ethernet_fcs_check_pkg.sv
// Shared constants and types for the Ethernet receive FCS checker.
// The CRC constants are also used by the transmit-side generator.
package ethernet_fcs_check_pkg;

    localparam logic [31:0] CRC_PRESET  = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam int          DLY_BYTES   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    typedef struct packed {
        logic        fcs_ok;
        logic        runt;
        logic        giant;
        logic        abort;
        logic [15:0] len;
    } status_t;

endpackage

// File: rtl/eth_crc32_byte_next.sv
// One-byte CRC-32 step, MSB-first register with d[0] entering first
// (d[0] meets crc_in[31], d[7] meets crc_in[24]).
module eth_crc32_byte_next
    import ethernet_fcs_check_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] crc_w;

    always_comb begin
        crc_w = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_w = {crc_w[30:0], 1'b0} ^ ((crc_w[31] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        crc_out = crc_w;
    end

endmodule

// File: rtl/ethernet_fcs_check.sv
// Receive-side FCS checker: strips the 4 FCS bytes through a delay line,
// validates CRC and length, and reports one status pulse per frame.
module ethernet_fcs_check
    import ethernet_fcs_check_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  d,
    input  logic        d_valid,
    input  logic        sof,
    input  logic        eof,
    output logic [7:0]  out_d,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic        status_valid,
    output logic        status_fcs_ok,
    output logic        status_runt,
    output logic        status_giant,
    output logic        status_abort,
    output logic [15:0] status_len,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
);

    state_t                        state_q, state_d;
    logic [31:0]                   crc_q, crc_d, crc_in, crc_next;
    logic [15:0]                   cnt_q, cnt_d, cnt_inc;
    logic [DLY_BYTES-1:0][7:0]     dly_q, dly_d;
    status_t                       pend_q, pend_d, st_q, st_d, s_a, s_e;
    logic                          pend_vld_q, pend_vld_d, st_vld_q, st_vld_d;
    logic                          have_a, have_e, in_frame;
    logic [7:0]                    out_d_q, out_d_d;
    logic                          out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic                          out_eof_q, out_eof_d, out_err_q, out_err_d;
    logic [31:0]                   good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

    function automatic status_t make_status(input logic [15:0] len, input logic fcs_ok,
                                            input logic abort);
        status_t s;
        s        = '0;
        s.len    = len;
        s.abort  = abort;
        s.fcs_ok = fcs_ok & ~abort;
        s.runt   = int'(len) < MIN_LEN;
        s.giant  = int'(len) > MAX_LEN;
        return s;
    endfunction

    function automatic logic is_good(input status_t s);
        return s.fcs_ok & ~s.runt & ~s.giant & ~s.abort;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign crc_in = sof ? CRC_PRESET : crc_q;

    eth_crc32_byte_next u_crc (
        .crc_in  (crc_in),
        .d       (d),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (d_valid) begin
            if (sof)                               state_d = eof ? ST_IDLE : ST_FRAME;
            else if (state_q == ST_FRAME && eof)   state_d = ST_IDLE;
        end
    end

    always_comb begin
        in_frame    = (state_q == ST_FRAME);
        cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        out_d_d     = 8'h00;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_err_d   = 1'b0;
        have_a      = 1'b0;
        have_e      = 1'b0;
        s_a         = '0;
        s_e         = '0;
        if (d_valid) begin
            if (sof) begin
                // A sof inside a frame aborts it; the new frame starts on this beat.
                if (in_frame) begin
                    have_a = 1'b1;
                    s_a    = make_status(cnt_q, 1'b0, 1'b1);
                    if (cnt_q > 16'(DLY_BYTES)) begin
                        out_valid_d = 1'b1;
                        out_eof_d   = 1'b1;
                        out_err_d   = 1'b1;
                    end
                end
                crc_d = crc_next;
                cnt_d = 16'd1;
                dly_d = {dly_q[DLY_BYTES-2:0], d};
                if (eof) begin
                    have_e = 1'b1;
                    s_e    = make_status(16'd1, crc_next == CRC_RESIDUE, 1'b0);
                end
            end else if (in_frame) begin
                crc_d = crc_next;
                cnt_d = cnt_inc;
                dly_d = {dly_q[DLY_BYTES-2:0], d};
                if (cnt_q >= 16'(DLY_BYTES)) begin
                    out_valid_d = 1'b1;
                    out_d_d     = dly_q[DLY_BYTES-1];
                    out_sof_d   = (cnt_q == 16'(DLY_BYTES));
                end
                if (eof) begin
                    have_e    = 1'b1;
                    s_e       = make_status(cnt_inc, crc_next == CRC_RESIDUE, 1'b0);
                    out_eof_d = out_valid_d;
                    out_err_d = out_valid_d & ~is_good(s_e);
                end
            end
        end
    end

    // An abort plus a one-byte frame on the same beat yields two statuses; the
    // second waits one cycle. A pending slot implies IDLE, so no abort can collide.
    always_comb begin
        if (pend_vld_q) begin
            st_d       = pend_q;
            st_vld_d   = 1'b1;
            pend_d     = s_e;
            pend_vld_d = have_e;
        end else if (have_a) begin
            st_d       = s_a;
            st_vld_d   = 1'b1;
            pend_d     = s_e;
            pend_vld_d = have_e;
        end else begin
            st_d       = s_e;
            st_vld_d   = have_e;
            pend_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (st_vld_d) begin
            if (is_good(st_d)) good_cnt_d = sat_inc32(good_cnt_q);
            else               bad_cnt_d  = sat_inc32(bad_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q       <= CRC_PRESET;
            cnt_q       <= 16'd0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            st_q        <= '0;
            st_vld_q    <= 1'b0;
            out_d_q     <= 8'h00;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_err_q   <= 1'b0;
            good_cnt_q  <= 32'd0;
            bad_cnt_q   <= 32'd0;
        end else begin
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            st_q        <= st_d;
            st_vld_q    <= st_vld_d;
            out_d_q     <= out_d_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            out_err_q   <= out_err_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    // Delay-line contents are only meaningful below cnt_q, so they need no reset.
    always_ff @(posedge clk) begin
        dly_q <= dly_d;
    end

    assign out_d         = out_d_q;
    assign out_valid     = out_valid_q;
    assign out_sof       = out_sof_q;
    assign out_eof       = out_eof_q;
    assign out_err       = out_err_q;
    assign status_valid  = st_vld_q;
    assign status_fcs_ok = st_q.fcs_ok;
    assign status_runt   = st_q.runt;
    assign status_giant  = st_q.giant;
    assign status_abort  = st_q.abort;
    assign status_len    = st_q.len;
    assign good_cnt      = good_cnt_q;
    assign bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_ethernet_fcs_check.sv
// Bench for ethernet_fcs_check: frame-level reference model (reflected CRC-32)
// with a per-cycle compare process, plus directed scenarios with literal pins.
module tb_ethernet_fcs_check;

    logic        clk = 1'b0;
    logic        reset, d_valid, sof, eof;
    logic [7:0]  d;
    logic [7:0]  out_d;
    logic        out_valid, out_sof, out_eof, out_err;
    logic        status_valid, status_fcs_ok, status_runt, status_giant, status_abort;
    logic [15:0] status_len;
    logic [31:0] good_cnt, bad_cnt;

    ethernet_fcs_check dut (
        .clk(clk), .reset(reset), .d(d), .d_valid(d_valid), .sof(sof), .eof(eof),
        .out_d(out_d), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .out_err(out_err), .status_valid(status_valid), .status_fcs_ok(status_fcs_ok),
        .status_runt(status_runt), .status_giant(status_giant), .status_abort(status_abort),
        .status_len(status_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] d; logic v; logic sof; logic eof; logic rst; } beat_t;
    typedef struct { int e; logic [7:0] d; logic sof; logic eof; logic err; } pay_t;
    typedef struct { int e; logic fcs_ok; logic runt; logic giant; logic abort;
                     logic [15:0] len; logic [31:0] good; logic [31:0] bad; } st_t;

    beat_t plan[$];
    pay_t  exp_pay[$];
    st_t   exp_st[$];
    int    cyc = 0;
    int    errors = 0, checks = 0;
    bit    chk_en = 0;
    int    m_good = 0, m_bad = 0;
    bit    m_in_f = 0;
    bq_t   m_cur;
    int    m_ed[$];

    int          beats_seen = 0, st_seen = 0, err_beats = 0;
    logic [7:0]  last_eof_d = 8'h00;
    logic        last_err = 0, last_fcs_ok = 0, last_runt = 0, last_giant = 0;
    logic [15:0] last_len = 16'h0, abort_len = 16'h0;
    pay_t        cp;
    st_t         cs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reflected (LSB-first) CRC-32 register, no final inversion.
    function automatic logic [31:0] crc_raw(input bq_t b);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bq_t make_frame(input logic [7:0] start, input int n);
        bq_t q;
        logic [31:0] c;
        for (int i = 0; i < n; i++) q.push_back(8'(start + i));
        c = ~crc_raw(q);
        q.push_back(c[7:0]); q.push_back(c[15:8]); q.push_back(c[23:16]); q.push_back(c[31:24]);
        return q;
    endfunction

    task automatic add_frame(input bq_t b, input int gap_pct, input bit term);
        beat_t bt;
        for (int i = 0; i < b.size(); i++) begin
            if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bt = '{d: 8'($urandom), v: 1'b0, sof: 1'($urandom), eof: 1'($urandom), rst: 1'b0};
                plan.push_back(bt);
            end
            bt = '{d: b[i], v: 1'b1, sof: (i == 0), eof: term && (i == b.size() - 1), rst: 1'b0};
            plan.push_back(bt);
        end
    endtask

    task automatic add_beat(input logic [7:0] bd, input logic v, input logic s,
                            input logic e, input logic r);
        beat_t bt;
        bt = '{d: bd, v: v, sof: s, eof: e, rst: r};
        plan.push_back(bt);
    endtask

    // kind 0: normal end, 1: aborted by sof at edge e, 2: discarded by reset
    task automatic model_finish(input bq_t b, input int ed[$], input int kind, input int e);
        int n = b.size();
        logic [15:0] len = (n > 65535) ? 16'hFFFF : 16'(n);
        logic fok  = (kind == 0) && (crc_raw(b) == 32'hDEBB_20E3);
        logic runt = (int'(len) < 64);
        logic giant = (int'(len) > 1522);
        logic good = fok && !runt && !giant;
        pay_t p;
        st_t  s;
        for (int j = 1; j <= n - 4; j++) begin
            p = '{e: ed[j+3], d: b[j-1], sof: (j == 1), eof: (kind == 0) && (j == n - 4),
                  err: (kind == 0) && (j == n - 4) && !good};
            exp_pay.push_back(p);
        end
        if (kind == 1 && n >= 5) begin
            p = '{e: e, d: 8'h00, sof: 1'b0, eof: 1'b1, err: 1'b1};
            exp_pay.push_back(p);
        end
        if (kind != 2) begin
            if (good) m_good++; else m_bad++;
            s = '{e: e, fcs_ok: fok, runt: runt, giant: giant, abort: (kind == 1), len: len,
                  good: 32'(m_good), bad: 32'(m_bad)};
            exp_st.push_back(s);
        end
    endtask

    task automatic run_plan();
        int base, e;
        for (int i = 0; i < 3; i++) add_beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        base = cyc + 1;
        for (int i = 0; i < plan.size(); i++) begin
            e = base + i;
            if (plan[i].rst) begin
                if (m_in_f) model_finish(m_cur, m_ed, 2, e);
                m_in_f = 0; m_good = 0; m_bad = 0;
                continue;
            end
            if (!plan[i].v) continue;
            if (plan[i].sof) begin
                if (m_in_f) model_finish(m_cur, m_ed, 1, e);
                m_cur = {plan[i].d}; m_ed = {e}; m_in_f = 1;
            end else if (m_in_f) begin
                m_cur.push_back(plan[i].d); m_ed.push_back(e);
            end else continue;
            if (plan[i].eof) begin
                model_finish(m_cur, m_ed, 0, e);
                m_in_f = 0;
            end
        end
        for (int i = 0; i < plan.size(); i++) begin
            reset = plan[i].rst; d_valid = plan[i].v; d = plan[i].d;
            sof = plan[i].sof; eof = plan[i].eof;
            @(posedge clk); #1;
        end
        reset = 0; d_valid = 0; sof = 0; eof = 0; d = 8'h00;
        plan.delete();
    endtask

    always @(negedge clk) if (chk_en) begin
        if (exp_pay.size() > 0 && exp_pay[0].e < cyc) begin
            chk(1'b0, "payload_missing", 32'(cyc), 32'(exp_pay[0].e));
            void'(exp_pay.pop_front());
        end
        if (exp_pay.size() > 0 && exp_pay[0].e == cyc) begin
            cp = exp_pay.pop_front();
            chk({out_valid, out_d, out_sof, out_eof, out_err} == {1'b1, cp.d, cp.sof, cp.eof, cp.err},
                "payload_beat", {20'h0, out_valid, out_d, out_sof, out_eof, out_err},
                {20'h0, 1'b1, cp.d, cp.sof, cp.eof, cp.err});
        end else begin
            chk(out_valid == 1'b0, "unexpected_out_valid", 32'(out_valid), 32'h0);
        end
        if (exp_st.size() > 0 && exp_st[0].e < cyc) begin
            chk(1'b0, "status_missing", 32'(cyc), 32'(exp_st[0].e));
            void'(exp_st.pop_front());
        end
        if (exp_st.size() > 0 && exp_st[0].e == cyc) begin
            cs = exp_st.pop_front();
            chk({status_valid, status_fcs_ok, status_runt, status_giant, status_abort, status_len}
                == {1'b1, cs.fcs_ok, cs.runt, cs.giant, cs.abort, cs.len}, "status_fields",
                {11'h0, status_valid, status_fcs_ok, status_runt, status_giant, status_abort, status_len},
                {11'h0, 1'b1, cs.fcs_ok, cs.runt, cs.giant, cs.abort, cs.len});
            chk(good_cnt == cs.good, "good_cnt", good_cnt, cs.good);
            chk(bad_cnt == cs.bad, "bad_cnt", bad_cnt, cs.bad);
        end else begin
            chk(status_valid == 1'b0, "unexpected_status", 32'(status_valid), 32'h0);
        end
        if (out_valid) begin
            beats_seen++;
            if (out_err) err_beats++;
            if (out_eof) begin last_eof_d = out_d; last_err = out_err; end
        end
        if (status_valid) begin
            st_seen++;
            last_fcs_ok = status_fcs_ok; last_runt = status_runt;
            last_giant = status_giant; last_len = status_len;
            if (status_abort) abort_len = status_len;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good, f, part, str;
        int b0, s0, e0;
        reset = 1; d_valid = 0; sof = 0; eof = 0; d = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk({out_valid, out_sof, out_eof, out_err, out_d} == 12'h0, "reset_out",
            {20'h0, out_valid, out_sof, out_eof, out_err, out_d}, 32'h0);
        chk({status_valid, status_fcs_ok, status_runt, status_giant, status_abort, status_len} == 21'h0,
            "reset_status", {11'h0, status_valid, status_fcs_ok, status_runt, status_giant,
            status_abort, status_len}, 32'h0);
        chk(good_cnt == 32'h0 && bad_cnt == 32'h0, "reset_counters", good_cnt | bad_cnt, 32'h0);
        reset = 0;
        chk_en = 1;

        // Model pins: standard CRC-32 check value and residue of a good frame
        str = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk(~crc_raw(str) == 32'hCBF4_3926, "model_crc_check", ~crc_raw(str), 32'hCBF4_3926);
        good = make_frame(8'h00, 60);
        chk(crc_raw(good) == 32'hDEBB_20E3, "model_residue", crc_raw(good), 32'hDEBB_20E3);

        // Good 64-byte frame
        b0 = beats_seen;
        add_frame(good, 0, 1); run_plan();
        chk(beats_seen - b0 == 60, "good_beats", 32'(beats_seen - b0), 32'd60);
        chk(last_eof_d == 8'h3B && last_err == 0, "good_eof_byte", {23'h0, last_err, last_eof_d}, 32'h3B);
        chk(last_fcs_ok == 1 && last_len == 16'd64, "good_status", {15'h0, last_fcs_ok, last_len}, 32'h1_0040);
        chk(good_cnt == 32'd1, "good_cnt_1", good_cnt, 32'd1);

        // Bit 0 of byte 10 flipped
        f = good; f[10] = f[10] ^ 8'h01;
        add_frame(f, 0, 1); run_plan();
        chk(last_fcs_ok == 0 && last_err == 1, "flip_err", {30'h0, last_fcs_ok, last_err}, 32'h1);
        chk(bad_cnt == 32'd1 && good_cnt == 32'd1, "flip_counters", bad_cnt, 32'd1);

        // 3-byte runt then single-beat sof&eof
        b0 = beats_seen;
        add_frame({8'hA1, 8'hA2, 8'hA3}, 0, 1); run_plan();
        chk(last_len == 16'd3 && last_runt == 1, "runt3", {15'h0, last_runt, last_len}, 32'h1_0003);
        add_beat(8'h55, 1'b1, 1'b1, 1'b1, 1'b0); run_plan();
        chk(last_len == 16'd1 && last_runt == 1, "runt1", {15'h0, last_runt, last_len}, 32'h1_0001);
        chk(beats_seen == b0, "runt_no_payload", 32'(beats_seen - b0), 32'd0);

        // Abort: sof arrives as byte 20 of frame A
        e0 = err_beats;
        part = make_frame(8'h40, 60);
        part = part[0:18];
        add_frame(part, 0, 0);
        add_frame(make_frame(8'h10, 60), 0, 1); run_plan();
        chk(abort_len == 16'd19, "abort_len", 32'(abort_len), 32'd19);
        chk(err_beats - e0 == 1, "abort_err_beat", 32'(err_beats - e0), 32'd1);
        chk(last_fcs_ok == 1 && last_len == 16'd64, "after_abort_good", {15'h0, last_fcs_ok, last_len}, 32'h1_0040);
        chk(good_cnt == 32'd2 && bad_cnt == 32'd4, "abort_counters", {good_cnt[15:0], bad_cnt[15:0]}, 32'h0002_0004);

        // Same good frame with 50% stall beats
        b0 = beats_seen;
        add_frame(good, 50, 1); run_plan();
        chk(beats_seen - b0 == 60 && last_eof_d == 8'h3B, "gaps_payload", 32'(beats_seen - b0), 32'd60);
        chk(last_fcs_ok == 1 && last_len == 16'd64, "gaps_status", {15'h0, last_fcs_ok, last_len}, 32'h1_0040);
        chk(good_cnt == 32'd3, "gaps_good_cnt", good_cnt, 32'd3);

        // Reset in the middle of a frame
        s0 = st_seen;
        part = good[0:28];
        add_frame(part, 0, 0);
        add_beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        add_beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        run_plan();
        chk(st_seen == s0, "reset_no_status", 32'(st_seen - s0), 32'd0);
        chk(good_cnt == 32'd0 && bad_cnt == 32'd0, "reset_mid_counters", good_cnt | bad_cnt, 32'd0);
        add_frame(good, 0, 1); run_plan();
        chk(good_cnt == 32'd1 && bad_cnt == 32'd0, "post_reset_good", good_cnt, 32'd1);

        // Stray bytes in IDLE, then back-to-back frames with no gap
        s0 = st_seen;
        add_beat(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        add_beat(8'h78, 1'b1, 1'b0, 1'b1, 1'b0);
        add_frame(good, 0, 1);
        add_frame(make_frame(8'h80, 60), 0, 1);
        run_plan();
        chk(st_seen - s0 == 2 && good_cnt == 32'd3, "back_to_back", {16'(st_seen - s0), good_cnt[15:0]}, 32'h0002_0003);

        // Giant frame: 1523 bytes including FCS
        add_frame(make_frame(8'h00, 1519), 0, 1); run_plan();
        chk(last_giant == 1 && last_len == 16'd1523 && last_fcs_ok == 1, "giant",
            {14'h0, last_giant, last_fcs_ok, last_len}, {14'h0, 2'b11, 16'd1523});
        chk(bad_cnt == 32'd1, "giant_bad_cnt", bad_cnt, 32'd1);

        for (int i = 0; i < 5; i++) add_beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        run_plan();
        chk(exp_pay.size() == 0, "payload_drain", 32'(exp_pay.size()), 32'd0);
        chk(exp_st.size() == 0, "status_drain", 32'(exp_st.size()), 32'd0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ethernet_fcs_check.md
ETHERNET_FCS_CHECK -- requirements
Module: ethernet_fcs_check

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes including FCS.
REQ-002 Parameter MAX_LEN, default 1522, maximum legal frame length in bytes including FCS.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 d  input  8  received frame byte, FCS last; bit mapping: d[7] combines with crc_reg[24], d[0] with crc_reg[31], same as the team's transmit CRC generator.
REQ-006 d_valid  input  1  d, sof and eof qualifier; d_valid=0 beats are stalls.
REQ-007 sof / eof  input  1 each  first / last byte of frame; both may be set on one beat.
REQ-008 out_d  output  8  payload byte, FCS stripped.
REQ-009 out_valid / out_sof / out_eof / out_err  output  1 each  payload-stream qualifiers; out_err only with out_eof.
REQ-010 status_valid  output  1  one-cycle pulse per terminated frame.
REQ-011 status_fcs_ok, status_runt, status_giant, status_abort  output  1 each  frame status, valid with status_valid.
REQ-012 status_len  output  16  frame byte count including FCS, saturating at 16'hFFFF.
REQ-013 good_cnt / bad_cnt  output  32 each  saturating frame counters.

Function
REQ-014 CRC-32: polynomial 0x04C11DB7, register preset to 32'hFFFFFFFF on every sof beat, updated once per d_valid beat inside a frame, including FCS bytes.
REQ-015 status_fcs_ok = 1 when the CRC register after the eof byte equals residue 32'hC704DD7B.
REQ-016 FSM states IDLE, FRAME: IDLE->FRAME on sof&d_valid&!eof; FRAME->IDLE on eof&d_valid; sof&eof on one beat stays/returns IDLE after a 1-byte frame.
REQ-017 d_valid beats without sof in IDLE are dropped with no output and no status.
REQ-018 Stall beats (d_valid=0) change no state, counter, CRC or delay-line content.
REQ-019 4-byte delay line: on frame byte k (k>=5) byte k-4 is presented on out_d one cycle later with out_valid=1; out_sof on the first such byte (k=5).
REQ-020 On eof beat with N>=5 bytes, byte N-4 is emitted with out_eof=1; FCS bytes are never emitted.
REQ-021 Frames with N<=4 bytes emit no payload beats, only status.
REQ-022 status_valid pulses one cycle after the eof beat, coincident with out_eof when present.
REQ-023 status_runt = (N < MIN_LEN); status_giant = (N > MAX_LEN); comparisons on saturated count.
REQ-024 good frame = fcs_ok & !runt & !giant & !abort; out_err = !good on the out_eof beat.
REQ-025 sof while in FRAME: previous frame aborted -- status pulse with abort=1, fcs_ok=0, len = bytes received before the sof; 4 buffered bytes discarded; new frame starts on that same beat.
REQ-026 On abort, if payload beats were already emitted, a terminating beat out_valid=1, out_eof=1, out_err=1, out_d=8'h00 follows one cycle after the sof beat.
REQ-027 good_cnt increments on each good status, bad_cnt on each other status; both hold at 32'hFFFFFFFF.
REQ-028 Back-to-back frames (eof then sof next beat, or sof on the beat after eof with no gap) carry no bubble requirement and lose no status.

Reset
REQ-029 Reset forces IDLE, CRC 32'hFFFFFFFF, delay line empty, byte count 0, counters 0, all outputs 0.
REQ-030 Reset mid-frame discards the frame silently: no status pulse, no out_eof.

Structure
REQ-031 Shared package holds CRC preset 32'hFFFFFFFF, residue 32'hC704DD7B, polynomial, FSM state typedef.
REQ-032 One combinational sub-module eth_crc32_byte_next computes next CRC from crc_reg and d; reusable by TX and RX.

Verification
REQ-033 64-byte frame, 60 bytes 0x00..0x3B plus correct FCS -> 60 out beats, out_eof on byte 0x3B, status fcs_ok=1, len=64, good_cnt=1.
REQ-034 Same frame with bit 0 of byte 10 flipped -> fcs_ok=0, out_err=1, bad_cnt=1.
REQ-035 3-byte frame, sof on byte 1, eof on byte 3 -> no out beats, runt=1, len=3; single-beat sof&eof -> len=1, runt=1.
REQ-036 sof at byte 20 of frame A -> abort status len=19, terminating err beat next cycle, frame B (64 bytes, good) passes with fcs_ok=1.
REQ-037 Random d_valid gaps (50%) on the 64-byte good frame -> identical payload and status as gap-free run.
REQ-038 Reset asserted at byte 30 then good 64-byte frame -> no status for partial frame, counters 0 then good_cnt=1.
